ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle CPU's 128x16 instruction memory.
- Drives the byte address each cycle and captures the returned 16-bit word into an instruction register (IR) with a valid/ready handshake to decode.
- Handles branch redirects and HALT detection.
- Sits between the instruction memory and the decode/control logic.

Parameters:
- ADDR_W, 8, byte address width (the word index is ADDR[7:1]).
- INSTR_W, 16, instruction width.
- RESET_PC, 8'h00, PC value after reset.
- HALT_WORD, 16'h0001, encoding that halts fetch.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  out  ADDR_W  byte address to instruction memory; always equals PC, always even.
- Q  in  INSTR_W  instruction word from memory (combinational read of ADDR).
- INSTR  out  INSTR_W  registered instruction (IR).
- INSTR_PC  out  ADDR_W  byte address INSTR was fetched from.
- INSTR_VALID  out  1  IR holds an unconsumed instruction.
- INSTR_READY  in  1  decode accepts INSTR this cycle.
- BR_TAKEN  in  1  redirect request from execute.
- BR_TARGET  in  ADDR_W  redirect byte address; bit 0 is ignored (forced to 0).
- HALTED  out  1  fetch stopped on HALT_WORD.
- RESUME  in  1  leave HALTED and continue at PC.

Behaviour:
- Reset (asynchronous): PC=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0, HALTED=0, state=BOOT.
- States: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset release with no capture, so the memory's synchronous reset-time image has settled. Then go to RUN.
  - RUN: capture occurs when !INSTR_VALID or INSTR_READY. On capture: INSTR<=Q, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+2.
  - RUN, no capture (INSTR_VALID=1 and INSTR_READY=0): PC, INSTR and INSTR_PC hold (stall).
  - RUN: if the captured Q==HALT_WORD, go to HALT. PC stays at the HALT address and is not incremented. HALTED<=1 in the same edge.
  - HALT: no further capture. The HALT instruction stays valid until consumed (INSTR_READY), then INSTR_VALID<=0.
  - HALT: RESUME=1 sets PC<=PC+2, clears HALTED and returns to RUN. RESUME is ignored outside HALT.
- PC arithmetic is modulo 2^ADDR_W: 0xFE+2 wraps to 0x00. PC bit 0 is always 0.
- Branch redirect, BR_TAKEN=1 in RUN:
  - Highest priority; overrides capture and stall.
  - PC<={BR_TARGET[7:1],1'b0}, INSTR_VALID<=0 (flush), no capture that cycle.
  - Fetch from the target starts on the next cycle.
  - If the same-cycle Q is HALT_WORD, it is discarded and HALT is not entered.
- BR_TAKEN in HALT: sets PC and flushes IR, but the block stays in HALT until RESUME. If both BR_TAKEN and RESUME are asserted, resume at the branch target (not PC+2).
- BR_TAKEN in BOOT: ignored.
- Latency: address to INSTR_VALID is 1 cycle. Sustained throughput is 1 instruction/cycle while INSTR_READY=1.
- Reset mid-stall or mid-halt: all state is discarded immediately and the block returns to BOOT.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - FETCH_CNT[15:0]: +1 per capture, saturates at 16'hFFFF.
  - STALL_CNT[15:0]: +1 per RUN cycle with INSTR_VALID=1 and INSTR_READY=0, saturates at 16'hFFFF.
  - Both reset to 0.
- When not defined, neither port nor counter logic exists and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Widths: ADDR_W, INSTR_W.
  - HALT_WORD and RESET_PC constants.
  - Fetch-state enum: BOOT, RUN, HALT.
- One natural sub-module: ifetch_pc_next. This is a combinational next-PC select with priority branch > resume > increment > hold, including wrap and bit-0 masking.
- The IR/handshake logic and FSM stay in ifetch_unit.

Test Plan:
- Straight line: memory holds SUB, then ADDI at 0x02 and 0x04. Release reset with READY=1 -> BOOT for 1 cycle, then INSTR_PC=0x00,0x02,0x04 on consecutive cycles with INSTR_VALID=1 each cycle, and ADDR tracking PC.
- Stall: hold READY=0 for 3 cycles after the first capture -> INSTR (0xF001) and ADDR (0x02) are stable and INSTR_VALID=1. On READY=1, the next captured word has INSTR_PC=0x02.
- Branch: BR_TAKEN=1, BR_TARGET=0x0B while INSTR_PC=0x06 -> next cycle INSTR_VALID=0 and ADDR=0x0A. The following cycle INSTR_PC=0x0A.
- Halt: word 0x0001 at 0x02 -> HALTED=1, ADDR frozen at 0x02, INSTR=0x0001 valid until READY, then INSTR_VALID=0. RESUME -> ADDR=0x04, HALTED=0.
- Wrap: branch to 0xFE with a non-halt word there -> next fetch address is 0x00.
- Async reset: assert RESET mid-stall, between clock edges -> all outputs go to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU widths, fetch constants and the fetch-state encoding.
package cpu_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0001;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/ifetch_pc_next.sv
// Combinational next-PC select: branch > resume > increment > hold.
module ifetch_pc_next
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              resume_en,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc_next
);
  logic [ADDR_W-1:0] pc_inc;

  // Modulo 2^ADDR_W wrap comes for free from the truncating add.
  assign pc_inc = pc + ADDR_W'(2);

  always_comb begin
    pc_next = pc;
    if (br_en)
      pc_next = {br_target[ADDR_W-1:1], 1'b0};
    else if (resume_en || inc_en)
      pc_next = {pc_inc[ADDR_W-1:1], 1'b0};
  end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, IR with valid/ready to decode, branch flush and HALT.
// Optional perf counters (FETCH_CNT/STALL_CNT) when IFETCH_PERF_CNT_EN is defined.
module ifetch_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  output logic [ADDR_W-1:0]  ADDR,
  input  logic [INSTR_W-1:0] Q,
  output logic [INSTR_W-1:0] INSTR,
  output logic [ADDR_W-1:0]  INSTR_PC,
  output logic               INSTR_VALID,
  input  logic               INSTR_READY,
  input  logic               BR_TAKEN,
  input  logic [ADDR_W-1:0]  BR_TARGET,
  output logic               HALTED,
  input  logic               RESUME
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0]        FETCH_CNT,
  output logic [15:0]        STALL_CNT
`endif
);
  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              in_run, in_halt, br_en, capture, is_halt, stall;

  assign in_run  = (state == RUN);
  assign in_halt = (state == HALT);
  assign br_en   = BR_TAKEN && (state != BOOT);
  assign capture = in_run && !BR_TAKEN && (!INSTR_VALID || INSTR_READY);
  assign is_halt = (Q == HALT_WORD);
  assign stall   = in_run && INSTR_VALID && !INSTR_READY;
  assign ADDR    = pc;

  ifetch_pc_next u_pc_next (
    .pc        (pc),
    .br_en     (br_en),
    .br_target (BR_TARGET),
    .resume_en (in_halt && RESUME),
    .inc_en    (capture && !is_halt),
    .pc_next   (pc_nxt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      INSTR       <= '0;
      INSTR_PC    <= '0;
      INSTR_VALID <= 1'b0;
      HALTED      <= 1'b0;
    end else begin
      pc <= pc_nxt;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (BR_TAKEN) begin
            INSTR_VALID <= 1'b0;
          end else if (capture) begin
            INSTR       <= Q;
            INSTR_PC    <= pc;
            INSTR_VALID <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              HALTED <= 1'b1;
            end
          end
        end
        HALT: begin
          // No capture here; only consume/flush the held HALT and wait for RESUME.
          if (BR_TAKEN || INSTR_READY) INSTR_VALID <= 1'b0;
          if (RESUME) begin
            state  <= RUN;
            HALTED <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FETCH_CNT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (capture && FETCH_CNT != 16'hFFFF) FETCH_CNT <= FETCH_CNT + 16'd1;
      if (stall && STALL_CNT != 16'hFFFF)   STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif
endmodule
